// File: rtl/tick_pkg.sv
// tick_pkg: shared types and defaults for the multi-channel tick generator.
//   tick_mode_e  - per-channel mode latched on load (periodic / one-shot)
//   chan_state_e - per-channel state (idle / running)
//   TICK_WIDTH_DEF, TICK_CHANNELS_DEF - default counter width and channel count
package tick_pkg;

  localparam int TICK_WIDTH_DEF    = 32;
  localparam int TICK_CHANNELS_DEF = 4;

  typedef enum logic {
    TICK_PERIODIC = 1'b0,
    TICK_ONESHOT  = 1'b1
  } tick_mode_e;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } chan_state_e;

endpackage

// File: rtl/tick_chan.sv
// tick_chan: one programmable tick channel.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   en     - count enable (level), ignored when idle or loading
//   mode   - 0 periodic / 1 one-shot, latched on load
//   load   - latch period/mode and restart the count
//   period - period in cycles; 0 leaves the channel idle
//   tick   - registered one-cycle strobe on terminal count
//   busy   - channel armed and counting
//   count  - current counter value
module tick_chan
  import tick_pkg::*;
#(
  parameter int WIDTH = TICK_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] period,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  chan_state_e      state_r, state_s;
  tick_mode_e       mode_r, mode_s;
  logic [WIDTH-1:0] per_r, per_s;
  logic [WIDTH-1:0] cnt_r, cnt_s;
  logic             tick_r, tick_s;
  logic [WIDTH-1:0] per_last_s;

  // Terminal count value; per_r is never 0 while running, so no underflow matters.
  assign per_last_s = per_r - ONE_C;

  // Next-state and next-output logic for the channel.
  always_comb begin
    state_s = state_r;
    mode_s  = mode_r;
    per_s   = per_r;
    cnt_s   = cnt_r;
    tick_s  = 1'b0;
    if (load) begin
      // Load wins over counting and restarts from zero without a tick.
      per_s  = period;
      mode_s = tick_mode_e'(mode);
      cnt_s  = ZERO_C;
      if (period != ZERO_C) begin
        state_s = CH_RUN;
      end else begin
        state_s = CH_IDLE;
      end
    end else begin
      case (state_r)
        CH_IDLE: begin
          cnt_s = cnt_r;
        end
        CH_RUN: begin
          if (en) begin
            if (cnt_r < per_last_s) begin
              cnt_s = cnt_r + ONE_C;
            end else begin
              cnt_s  = ZERO_C;
              tick_s = 1'b1;
              if (mode_r == TICK_ONESHOT) begin
                state_s = CH_IDLE;
              end else begin
                state_s = CH_RUN;
              end
            end
          end else begin
            // Paused: hold the count and never emit a tick.
            cnt_s = cnt_r;
          end
        end
        default: begin
          state_s = CH_IDLE;
        end
      endcase
    end
  end

  // Channel state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CH_IDLE;
      mode_r  <= TICK_PERIODIC;
      per_r   <= ZERO_C;
      cnt_r   <= ZERO_C;
      tick_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      mode_r  <= mode_s;
      per_r   <= per_s;
      cnt_r   <= cnt_s;
      tick_r  <= tick_s;
    end
  end

  assign tick  = tick_r;
  assign busy  = (state_r == CH_RUN);
  assign count = cnt_r;

endmodule

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: CHANNELS independent programmable tick generators.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   en     - per-channel count enable
//   mode   - per-channel mode (0 periodic, 1 one-shot), latched on load
//   load   - per-channel load strobe
//   period - flattened periods, channel i at [i*WIDTH +: WIDTH]
//   tick   - per-channel registered one-cycle tick strobe
//   busy   - per-channel armed/counting flag
//   count  - flattened counter values for readback
module tick_gen_multi
  import tick_pkg::*;
#(
  parameter int WIDTH    = TICK_WIDTH_DEF,
  parameter int CHANNELS = TICK_CHANNELS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] period,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS*WIDTH-1:0] count
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    tick_chan #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (en[i]),
      .mode   (mode[i]),
      .load   (load[i]),
      .period (period[i*WIDTH +: WIDTH]),
      .tick   (tick[i]),
      .busy   (busy[i]),
      .count  (count[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
module tb_tick_gen_multi;

  localparam int W = 8;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [C-1:0] en, mode, load;
  logic [C*W-1:0] period;
  logic [C-1:0] tick, busy;
  logic [C*W-1:0] count;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  load;
    logic [3:0]  mode;
    logic [3:0]  en;
    logic [31:0] period;
    logic [3:0]  etick;
    logic [3:0]  ebusy;
    logic [31:0] ecount;
  } vec_t;

  vec_t vt[$];

  tick_gen_multi #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .load   (load),
    .period (period),
    .tick   (tick),
    .busy   (busy),
    .count  (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(string nm, logic r, logic [3:0] ld, logic [3:0] md, logic [3:0] e,
                              logic [31:0] p, logic [3:0] et, logic [3:0] eb, logic [31:0] ec);
    vec_t v;
    v.name = nm; v.rst = r; v.load = ld; v.mode = md; v.en = e; v.period = p;
    v.etick = et; v.ebusy = eb; v.ecount = ec;
    return v;
  endfunction

  function automatic logic [W-1:0] cnt_of(int ch);
    return count[ch*W +: W];
  endfunction

  task automatic do_reset();
    rst = 1'b1; load = '0; en = '0; mode = '0; period = '0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int ticks;
    int first_at;
    int second_at;
    int p[4];
    logic [3:0]  et;
    logic [31:0] ec;

    // ---------------- reset with random inputs ----------------
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en = C'($urandom); mode = C'($urandom); load = C'($urandom); period = $urandom;
      cyc();
    end
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_count", count, 32'h0);
    rst = 1'b0; load = '0; en = C'($urandom); period = $urandom;
    cyc();
    chk("post_rst_tick", 32'(tick), 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);
    chk("post_rst_count", count, 32'h0);

    // ---------------- table: periodic ch0, period 5 ----------------
    vt.push_back(mk("per5_load", 1'b0, 4'b0001, 4'b0000, 4'b0001, 32'h0000_0005,
                    4'b0000, 4'b0001, 32'h0000_0000));
    for (int j = 1; j <= 15; j++) begin
      // From step 6 the period input changes without a load; it must be ignored.
      vt.push_back(mk($sformatf("per5_j%0d", j), 1'b0, 4'b0000, 4'b0000, 4'b0001,
                      (j >= 6) ? 32'h0000_0009 : 32'h0000_0005,
                      ((j % 5) == 0) ? 4'b0001 : 4'b0000, 4'b0001, 32'(j % 5)));
    end
    // Idle channels ignore en.
    vt.push_back(mk("idle_en", 1'b0, 4'b0000, 4'b0000, 4'b1111, 32'h0000_0009,
                    4'b0000, 4'b0001, 32'h0000_0001));
    // Reset overrides a load.
    vt.push_back(mk("rst_over_load", 1'b1, 4'b1111, 4'b0000, 4'b1111, 32'h0303_0303,
                    4'b0000, 4'b0000, 32'h0000_0000));

    for (int i = 0; i < vt.size(); i++) begin
      rst = vt[i].rst; load = vt[i].load; mode = vt[i].mode; en = vt[i].en; period = vt[i].period;
      cyc();
      chk({vt[i].name, "_tick"}, 32'(tick), 32'(vt[i].etick));
      chk({vt[i].name, "_busy"}, 32'(busy), 32'(vt[i].ebusy));
      chk({vt[i].name, "_count"}, count, vt[i].ecount);
    end

    // ---------------- one-shot ch1, period 3 ----------------
    do_reset();
    load = 4'b0010; mode = 4'b0010; en = 4'b0010; period = 32'h0000_0300;
    cyc();
    load = '0;
    chk("os_load_busy", 32'(busy[1]), 32'h1);
    cyc(); cyc();
    chk("os_j2_count", 32'(cnt_of(1)), 32'h2);
    chk("os_j2_tick", 32'(tick[1]), 32'h0);
    cyc();
    chk("os_j3_tick", 32'(tick[1]), 32'h1);
    chk("os_j3_busy", 32'(busy[1]), 32'h0);
    chk("os_j3_count", 32'(cnt_of(1)), 32'h0);
    ticks = 0;
    for (int j = 0; j < 20; j++) begin
      cyc();
      if (tick[1] === 1'b1 || busy[1] !== 1'b0) ticks++;
    end
    chk("os_quiet20", 32'(ticks), 32'h0);

    // ---------------- enable gating ch2, period 4 ----------------
    do_reset();
    load = 4'b0100; mode = '0; en = 4'b0100; period = 32'h0004_0000;
    cyc();
    load = '0;
    cyc(); cyc();
    chk("gate_j2_count", 32'(cnt_of(2)), 32'h2);
    en = '0;
    ticks = 0;
    for (int j = 0; j < 3; j++) begin
      cyc();
      if (tick[2] === 1'b1 || cnt_of(2) !== 8'd2) ticks++;
    end
    chk("gate_hold", 32'(ticks), 32'h0);
    en = 4'b0100;
    cyc();
    chk("gate_resume_count", 32'(cnt_of(2)), 32'h3);
    chk("gate_resume_tick", 32'(tick[2]), 32'h0);
    cyc();
    chk("gate_late_tick", 32'(tick[2]), 32'h1);
    ticks = 0;
    for (int j = 0; j < 3; j++) begin
      cyc();
      if (tick[2] === 1'b1) ticks++;
    end
    chk("gate_no_extra", 32'(ticks), 32'h0);
    cyc();
    chk("gate_next_tick", 32'(tick[2]), 32'h1);

    // ---------------- period 0 ----------------
    do_reset();
    load = 4'b1000; en = 4'b1000; period = 32'h0000_0000;
    cyc();
    load = '0;
    chk("p0_busy", 32'(busy[3]), 32'h0);
    ticks = 0;
    for (int j = 0; j < 5; j++) begin
      cyc();
      if (tick[3] === 1'b1 || busy[3] !== 1'b0) ticks++;
    end
    chk("p0_no_tick", 32'(ticks), 32'h0);

    // ---------------- period 1 periodic ----------------
    load = 4'b1000; mode = '0; en = 4'b1000; period = 32'h0100_0000;
    cyc();
    load = '0;
    chk("p1_load_tick", 32'(tick[3]), 32'h0);
    ticks = 0;
    for (int j = 0; j < 6; j++) begin
      cyc();
      if (tick[3] === 1'b1 && cnt_of(3) === 8'd0) ticks++;
    end
    chk("p1_continuous", 32'(ticks), 32'd6);

    // ---------------- period 1 one-shot ----------------
    load = 4'b1000; mode = 4'b1000; period = 32'h0100_0000;
    cyc();
    load = '0;
    ticks = 0;
    for (int j = 0; j < 6; j++) begin
      cyc();
      if (tick[3] === 1'b1) ticks++;
    end
    chk("p1_oneshot_ticks", 32'(ticks), 32'd1);
    chk("p1_oneshot_busy", 32'(busy[3]), 32'h0);

    // ---------------- period 255 ----------------
    do_reset();
    load = 4'b0001; mode = '0; en = 4'b0001; period = 32'h0000_00FF;
    cyc();
    load = '0;
    ticks = 0; first_at = -1; second_at = -1;
    for (int j = 1; j <= 520; j++) begin
      cyc();
      if (tick[0] === 1'b1) begin
        ticks++;
        if (first_at < 0) first_at = j;
        else if (second_at < 0) second_at = j;
      end
    end
    chk("p255_ticks", 32'(ticks), 32'd2);
    chk("p255_first", 32'(first_at), 32'd255);
    chk("p255_second", 32'(second_at), 32'd510);

    // ---------------- load at terminal count ----------------
    do_reset();
    load = 4'b0100; mode = '0; en = 4'b0100; period = 32'h0003_0000;
    cyc();
    load = '0;
    cyc(); cyc();
    chk("lt_j2_count", 32'(cnt_of(2)), 32'h2);
    load = 4'b0100;
    cyc();
    load = '0;
    chk("lt_tick", 32'(tick[2]), 32'h0);
    chk("lt_count", 32'(cnt_of(2)), 32'h0);
    chk("lt_busy", 32'(busy[2]), 32'h1);
    cyc(); cyc(); cyc();
    chk("lt_restart_tick", 32'(tick[2]), 32'h1);

    // ---------------- independence + mid-run reset ----------------
    do_reset();
    p[0] = 2; p[1] = 3; p[2] = 5; p[3] = 7;
    load = 4'b1111; mode = '0; en = 4'b1111; period = 32'h0705_0302;
    cyc();
    load = '0;
    chk("ind_load_busy", 32'(busy), 32'hF);
    for (int j = 1; j <= 40; j++) begin
      cyc();
      et = '0; ec = '0;
      for (int c = 0; c < 4; c++) begin
        et[c] = ((j % p[c]) == 0);
        ec[c*8 +: 8] = 8'(j % p[c]);
      end
      chk($sformatf("ind_tick_j%0d", j), 32'(tick), 32'(et));
      chk($sformatf("ind_count_j%0d", j), count, ec);
    end
    rst = 1'b1; load = 4'b1111;
    cyc();
    chk("mid_rst_tick", 32'(tick), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_count", count, 32'h0);
    rst = 1'b0; load = '0;
    cyc();
    chk("mid_rst_idle_busy", 32'(busy), 32'h0);
    chk("mid_rst_idle_count", count, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tick_gen_multi.md
# tick_gen_multi

Parametrised multi-channel programmable tick generator. It replaces the single fixed-period counter with `CHANNELS` independent channels. Each channel has its own loadable period, an enable, and a periodic or one-shot mode. It sits between the register/control interface and the timed peripherals (PWM, sampling, UART baud), and supplies single-cycle tick strobes.

## Interface
- `WIDTH`, 32, counter and period width in bits (≥2)
- `CHANNELS`, 4, number of independent channels (≥1)

- `clk` in 1: single clock; every register updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in `CHANNELS`: per-channel count enable; level-sensitive.
- `mode` in `CHANNELS`: per-channel mode, sampled on load; 0 = periodic, 1 = one-shot.
- `load` in `CHANNELS`: per-channel load strobe; latches `period`/`mode` and restarts the channel.
- `period` in `CHANNELS*WIDTH`: flattened periods; channel i uses bits [i*WIDTH +: WIDTH].
- `tick` out `CHANNELS`: registered one-cycle strobe per channel.
- `busy` out `CHANNELS`: channel armed and counting.
- `count` out `CHANNELS*WIDTH`: flattened current counter values, for debug/readback.

## Operation
- Per-channel state consists of `per_q` (WIDTH), `mode_q`, `cnt_q` (WIDTH), `busy_q` and `tick_q`.
- Reset values: all of `per_q`, `cnt_q`, `mode_q`, `busy`, `tick` and `count` are 0. All channels are idle after reset.
- Channel states:
  - IDLE (busy=0): the counter holds its value; `en` is ignored.
  - RUN (busy=1).
- Load (`load[i]`=1) applies in any state:
  - Sets `per_q`←`period[i]`, `mode_q`←`mode[i]`, `cnt_q`←0 and `tick_q`←0.
  - Sets busy←1 if `period[i]`≠0, otherwise busy←0.
  - Load has priority over counting; `en` is ignored in the load cycle.
- In RUN with `en[i]`=1 and no load:
  - If `cnt_q` < `per_q`−1: `cnt_q`←`cnt_q`+1 and `tick_q`←0.
  - Otherwise (`cnt_q` == `per_q`−1): `cnt_q`←0 and `tick_q`←1.
  - In that terminal cycle, one-shot mode also sets busy←0 (transition to IDLE).
- In RUN with `en[i]`=0: the counter holds and `tick_q`←0. A pause never produces or stretches a tick.
- Arithmetic:
  - The compare is unsigned at WIDTH bits.
  - `per_q`−1 never underflows, because `per_q`=0 cannot be in RUN.
  - Maximum period is 2^WIDTH−1.
- Period 1: in periodic mode `tick` is high on every enabled cycle; in one-shot mode there is exactly one tick.
- A new `period` value takes effect only on `load`; changing `period` without a load has no effect.
- Channels are fully independent. Simultaneous loads or ticks on different channels do not interact.

## Timing
- Load at edge k gives `count`=0 and busy=1 after edge k.
- With `en` held high, the first `tick` is high for the cycle following edge k+N (N = period). Later ticks occur every N cycles.
- `tick` is exactly one cycle wide, except period 1 in periodic mode with continuous `en`, where it stays high continuously.
- A one-shot channel's busy falls on the same edge where `tick` rises.
- A load in the same cycle as the terminal count restarts the channel: no tick, and `count`=0.
- `rst` asserted mid-operation returns every output to its reset value on the next edge. `rst` overrides `load`.
- Outputs are fully registered; there is no combinational path from input to output.

## Structure
- Package `tick_pkg` holds:
  - the `tick_mode_e` enum (`TICK_PERIODIC`=1'b0, `TICK_ONESHOT`=1'b1);
  - the default `WIDTH`/`CHANNELS` localparams.
- Sub-module `tick_chan` (parameter WIDTH) implements one channel. The top level instantiates it `CHANNELS` times with a generate loop and handles the flattened bus slicing.

## Test plan
- **Reset:** WIDTH=8, CHANNELS=4. Assert `rst` for 2 cycles with random inputs; after release, `tick`/`busy`/`count` are all 0.
- **Periodic:** channel 0 loads period=5 in periodic mode with `en`=1. Ticks appear at cycles 5, 10 and 15 after the load edge, each 1 cycle wide, and `count` cycles 0..4.
- **One-shot:** channel 1 loads period=3 in one-shot mode. It gives a single tick 3 cycles after the load, busy falls together with the tick, and no further ticks follow over the next 20 cycles.
- **Enable gating:** channel 2 runs period=4 and `en` drops for 3 cycles at count=2. The count holds at 2, and the tick arrives 3 cycles late with no extra ticks.
- **Edge cases:**
  - Period=0 load gives busy=0 and no tick.
  - Period=1 in periodic mode gives continuous `tick`.
  - Period=255 gives a tick every 255 cycles.
  - A load coinciding with the terminal count gives no tick and `count`=0.
- **Independence and mid-run reset:** all 4 channels run with periods 2, 3, 5 and 7; the tick pattern of each matches a reference model. Asserting `rst` mid-run clears every channel on the next edge.
